// File: rtl/bcd_disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_disp_pkg
//  Description : Shared constants and the nibble-to-glyph decode function for
//                the common-anode BCD display blocks. Segment vectors are
//                ordered {g,f,e,d,c,b,a} and are active-low (0 = lit).
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_disp_pkg;

  localparam int DEF_DIGITS      = 3;
  localparam int DEF_REFRESH_DIV = 50000;

  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  localparam logic [6:0] SEG_DASH    = 7'h3F;

  localparam logic [6:0] SEG_GLYPH_0 = 7'h40;
  localparam logic [6:0] SEG_GLYPH_1 = 7'h79;
  localparam logic [6:0] SEG_GLYPH_2 = 7'h24;
  localparam logic [6:0] SEG_GLYPH_3 = 7'h30;
  localparam logic [6:0] SEG_GLYPH_4 = 7'h19;
  localparam logic [6:0] SEG_GLYPH_5 = 7'h12;
  localparam logic [6:0] SEG_GLYPH_6 = 7'h02;
  localparam logic [6:0] SEG_GLYPH_7 = 7'h78;
  localparam logic [6:0] SEG_GLYPH_8 = 7'h00;
  localparam logic [6:0] SEG_GLYPH_9 = 7'h10;

  // Nibbles A-F are not valid BCD; they render as a dash so a corrupted
  // upstream value is visible rather than silently looking like a digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] s;
    case (nibble)
      4'd0:    s = SEG_GLYPH_0;
      4'd1:    s = SEG_GLYPH_1;
      4'd2:    s = SEG_GLYPH_2;
      4'd3:    s = SEG_GLYPH_3;
      4'd4:    s = SEG_GLYPH_4;
      4'd5:    s = SEG_GLYPH_5;
      4'd6:    s = SEG_GLYPH_6;
      4'd7:    s = SEG_GLYPH_7;
      4'd8:    s = SEG_GLYPH_8;
      4'd9:    s = SEG_GLYPH_9;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seg7_decode
//  Description : Combinational BCD nibble to active-low 7-segment decoder.
//  Ports       : i_nibble [3:0] - BCD digit (A-F decode to a dash)
//                o_seg    [6:0] - segments {g,f,e,d,c,b,a}, active-low
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = seg_decode(i_nibble);
  end

endmodule
`default_nettype wire

// File: rtl/bcd_seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_seg7_scan
//  Description : Time-multiplexed driver for a common-anode BCD 7-segment
//                display. Refresh divider, digit scan, frame-synchronous
//                value update and optional leading-zero blanking.
//  Ports       : clk        - system clock, rising edge
//                rst_n      - asynchronous active-low reset
//                bcd_in     - packed BCD, [4k+3:4k] = digit k (k=0 is LSD)
//                bcd_valid  - one-cycle strobe, bcd_in sampled when high
//                seg        - segments {g,f,e,d,c,b,a}, active-low
//                an         - anode enables, active-low, one-hot-low
//                frame_done - one-cycle pulse as the scan wraps to digit 0
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_seg7_scan
  import bcd_disp_pkg::*;
#(
  parameter int DIGITS      = DEF_DIGITS,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  bcd_valid,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pending_q, pending_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic                wrap_q, wrap_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_done_q, frame_done_d;

  logic                w_tick;
  logic                w_boundary;
  logic [3:0]          w_nibble;
  logic [6:0]          w_glyph;
  logic [DIGITS-1:0]   w_upper_zero;
  logic                w_blank;

  // w_upper_zero[k] is set when digit k and every digit above it are zero.
  for (genvar k = 0; k < DIGITS; k++) begin : g_lz
    assign w_upper_zero[k] = (shadow_q[4*DIGITS-1:4*k] == '0);
  end

  always_comb begin
    w_nibble = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        w_nibble = shadow_q[4*k +: 4];
      end
    end
  end

  bcd_seg7_decode u_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

  always_comb begin
    w_tick     = (div_q == DIV_LAST);
    w_boundary = w_tick && (idx_q == IDX_LAST);

    div_d = w_tick ? '0 : div_q + 1'b1;

    idx_d = idx_q;
    if (w_tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // A strobe coinciding with the boundary bypasses pending straight into
    // the shadow, because pending_d already carries the new value.
    pending_d = bcd_valid ? bcd_in : pending_q;
    shadow_d  = w_boundary ? pending_d : shadow_q;

    // wrap_q marks the first cycle of the new frame's state; frame_done is
    // registered once more so it lines up with digit 0 appearing on the pins.
    wrap_d       = w_boundary;
    frame_done_d = wrap_q;

    // Digit 0 is never blanked; blanked digits keep their anode active so
    // the scan duty cycle does not depend on the displayed value.
    w_blank = BLANK_LZ && (idx_q != '0) && w_upper_zero[idx_q];
    seg_d   = w_blank ? SEG_BLANK : w_glyph;
    an_d    = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      idx_q        <= '0;
      pending_q    <= '0;
      shadow_q     <= '0;
      wrap_q       <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      shadow_q     <= shadow_d;
      wrap_q       <= wrap_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_seg7_scan
//  Description : Self-checking bench for bcd_seg7_scan (DIGITS=3,
//                REFRESH_DIV=4). Two instances share stimulus: one with
//                leading-zero blanking, one without. Expected outputs come
//                from a cycle-count/frame-value model of the display.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_seg7_scan;

  localparam int D  = 3;
  localparam int R  = 4;
  localparam int RD = R * D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] bcd_in = '0;
  logic        bcd_valid = 1'b0;

  logic [6:0]  seg_a, seg_b;
  logic [2:0]  an_a, an_b;
  logic        fd_a, fd_b;

  int total = 0;
  int bad   = 0;

  bcd_seg7_scan #(.DIGITS(D), .REFRESH_DIV(R), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
    .seg(seg_a), .an(an_a), .frame_done(fd_a)
  );

  bcd_seg7_scan #(.DIGITS(D), .REFRESH_DIV(R), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
    .seg(seg_b), .an(an_b), .frame_done(fd_b)
  );

  initial forever #5 clk = ~clk;

  // Glyph table, index = nibble value.
  logic [6:0] glyph [16];
  initial begin
    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  end

  // ---------------- behavioural model ----------------
  // cyc counts rising edges since reset release. Output cycle c shows digit
  // ((c-1)/R)%D of the value belonging to frame (c-1)/RD. The value for frame
  // f>0 is the last strobe sampled on or before edge f*RD; frame 0 shows 0.
  int          cyc = 0;
  logic [11:0] last_val = '0;
  logic [11:0] frame_val [1024];
  logic [6:0]  exp_seg_a = 7'h7F, exp_seg_b = 7'h7F;
  logic [2:0]  exp_an = 3'b111;
  logic        exp_fd = 1'b0;

  initial begin
    int d, f;
    logic [11:0] v;
    logic [3:0]  nib;
    logic        blank;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        cyc = 0; last_val = '0; frame_val[0] = '0;
        exp_seg_a = 7'h7F; exp_seg_b = 7'h7F; exp_an = 3'b111; exp_fd = 1'b0;
      end else begin
        cyc++;
        if (bcd_valid) last_val = bcd_in;
        if ((cyc % RD == 0) && (cyc / RD < 1024)) frame_val[cyc / RD] = last_val;
        d = ((cyc - 1) / R) % D;
        f = (cyc - 1) / RD;
        v = (f < 1024) ? frame_val[f] : 12'h000;
        nib = v[4*d +: 4];
        blank = (d > 0) && ((v >> (4 * d)) == 12'h000);
        exp_seg_b = glyph[nib];
        exp_seg_a = blank ? 7'h7F : glyph[nib];
        exp_an    = ~(3'b001 << d);
        exp_fd    = (cyc > 1) && ((cyc - 1) % RD == 0);
      end
    end
  end

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_seg_a", 12'(seg_a), 12'h7F);
      chk("rst_an_a",  12'(an_a),  12'h7);
      chk("rst_fd_a",  12'(fd_a),  12'h0);
      chk("rst_seg_b", 12'(seg_b), 12'h7F);
    end else begin
      chk("seg_a", 12'(seg_a), 12'(exp_seg_a));
      chk("seg_b", 12'(seg_b), 12'(exp_seg_b));
      chk("an_a",  12'(an_a),  12'(exp_an));
      chk("an_b",  12'(an_b),  12'(exp_an));
      chk("fd_a",  12'(fd_a),  12'(exp_fd));
      chk("fd_b",  12'(fd_b),  12'(exp_fd));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      total++; bad++;
      $display("FAIL wait_cyc: reached cycle %0d expected %0d", cyc, n);
    end
  endtask

  task automatic strobe_at(input int n, input logic [11:0] v);
    wait_cyc(n);
    #1;
    bcd_in = v; bcd_valid = 1'b1;
    @(negedge clk);
    #1;
    bcd_valid = 1'b0;
  endtask

  function automatic logic [11:0] rand_bcd();
    logic [11:0] v;
    int r;
    v = '0;
    for (int k = 0; k < 3; k++) begin
      r = $urandom_range(0, 15);
      if (r < 6)       v[4*k +: 4] = 4'd0;
      else if (r < 14) v[4*k +: 4] = 4'($urandom_range(1, 9));
      else             v[4*k +: 4] = 4'($urandom_range(10, 15));
    end
    return v;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int c0, b;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    // Reset release, nothing strobed.
    wait_cyc(1);  chk("t1_an_c1", 12'(an_a), 12'h6); chk("t1_seg_c1", 12'(seg_a), 12'h40);
    wait_cyc(4);  chk("t1_an_c4", 12'(an_a), 12'h6);
    wait_cyc(5);  chk("t1_an_c5", 12'(an_a), 12'h5); chk("t1_seg_c5", 12'(seg_a), 12'h7F);
    wait_cyc(9);  chk("t1_an_c9", 12'(an_a), 12'h3); chk("t1_seg_c9", 12'(seg_a), 12'h7F);
    wait_cyc(12); chk("t1_fd_c12", 12'(fd_a), 12'h0);
    wait_cyc(13); chk("t1_fd_c13", 12'(fd_a), 12'h1); chk("t1_an_c13", 12'(an_a), 12'h6);

    // Mid-frame strobe waits for the next frame.
    strobe_at(15, 12'h167);
    wait_cyc(24); chk("t2_hold_c24", 12'(seg_a), 12'h7F);
    wait_cyc(25); chk("t2_d0", 12'(seg_a), 12'h78); chk("t2_fd", 12'(fd_a), 12'h1);
    wait_cyc(29); chk("t2_d1", 12'(seg_a), 12'h02);
    wait_cyc(33); chk("t2_d2", 12'(seg_a), 12'h79);

    // Leading-zero blanking vs. no blanking.
    strobe_at(38, 12'h045);
    wait_cyc(49); chk("t3_d0", 12'(seg_a), 12'h12);
    wait_cyc(53); chk("t3_d1", 12'(seg_a), 12'h19);
    wait_cyc(57); chk("t3_d2_blank", 12'(seg_a), 12'h7F); chk("t3_d2_noblank", 12'(seg_b), 12'h40);

    // Two strobes in one frame: last wins.
    strobe_at(62, 12'h255);
    strobe_at(65, 12'h065);
    wait_cyc(73); chk("t4_d0", 12'(seg_a), 12'h12);
    wait_cyc(77); chk("t4_d1", 12'(seg_a), 12'h02);
    wait_cyc(81); chk("t4_d2", 12'(seg_a), 12'h7F);

    // Strobe sampled on the boundary edge goes straight to the display.
    strobe_at(95, 12'h2A0);
    wait_cyc(97);  chk("t5_d0", 12'(seg_a), 12'h40);
    wait_cyc(101); chk("t5_d1", 12'(seg_a), 12'h3F);
    wait_cyc(105); chk("t5_d2", 12'(seg_a), 12'h24);

    // Random strobes, checked every cycle against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      bcd_valid = ($urandom_range(0, 4) == 0);
      bcd_in    = rand_bcd();
    end
    @(negedge clk);
    #1 bcd_valid = 1'b0;

    // Asynchronous reset while 255 is on display.
    c0 = cyc + 2;
    strobe_at(c0, 12'h255);
    b = ((c0 + RD) / RD) * RD;
    wait_cyc(b + 6);
    chk("t6_before_rst_d1", 12'(seg_a), 12'h12);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_an",  12'(an_a),  12'h7);
    chk("t6_async_seg", 12'(seg_a), 12'h7F);
    chk("t6_async_fd",  12'(fd_a),  12'h0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_cyc(1);  chk("t6_restart_an", 12'(an_a), 12'h6); chk("t6_restart_seg", 12'(seg_a), 12'h40);
    wait_cyc(13); chk("t6_pending_dropped", 12'(seg_a), 12'h40);
    wait_cyc(17); chk("t6_pending_dropped_d1", 12'(seg_a), 12'h7F);
    wait_cyc(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
